// File: rtl/dcp_mem_responder.sv
// Fixed-latency memory-side responder for the DCP line-request interface.
// Requests queue in order and return a line from an internal store LAT cycles after accept.
module dcp_mem_responder #(
   parameter int              LINE_W    = 512,
   parameter int              NUM_LINES = 256,
   parameter logic [39:0]     BASE_ADDR = 40'h0,
   parameter int              DEPTH     = 8,
   parameter int              LAT       = 4,
   localparam int             PADDR_W   = 40,
   localparam int             IDX_W     = $clog2(NUM_LINES),
   localparam int             CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mem_req_val,
   output logic               mem_req_rdy,
   input  logic [5:0]         mem_req_transid,
   input  logic [PADDR_W-1:0] mem_req_addr,
   input  logic               hold,
   input  logic               wr_en,
   input  logic [IDX_W-1:0]   wr_idx,
   input  logic [LINE_W-1:0]  wr_data,
   output logic               mem_resp_val,
   output logic [5:0]         mem_resp_transid,
   output logic [LINE_W-1:0]  mem_resp_data,
   output logic               mem_resp_err,
   output logic [CNT_W-1:0]   q_count
);

   localparam int                 PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0]   FULL     = CNT_W'(DEPTH);
   localparam logic [7:0]         ELIG_AGE = 8'(LAT - 1);
   localparam logic [PADDR_W-1:0] NL       = PADDR_W'(NUM_LINES);

   logic [LINE_W-1:0] line_mem [NUM_LINES];

   logic [5:0]        ent_tid_q [DEPTH];
   logic [IDX_W-1:0]  ent_idx_q [DEPTH];
   logic              ent_err_q [DEPTH];
   logic [7:0]        ent_ts_q  [DEPTH];

   logic [PTR_W-1:0]  wptr_q, rptr_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        now_q;
   logic              resp_val_q, resp_err_q;
   logic [5:0]        resp_tid_q;
   logic [LINE_W-1:0] rd_q;

   logic [PADDR_W-1:0] off, line_no;
   logic               req_err;
   logic [IDX_W-1:0]   req_idx;
   logic               accept, issue;
   logic [7:0]         age;

   // Modulo-2^40 subtraction makes addresses below BASE land far out of range.
   assign off     = (mem_req_addr & ~PADDR_W'(63)) - BASE_ADDR;
   assign line_no = off >> 6;
   assign req_err = line_no >= NL;
   assign req_idx = line_no[IDX_W-1:0];

   assign mem_req_rdy = (cnt_q != FULL);
   assign accept      = mem_req_val && mem_req_rdy;
   assign age         = now_q - ent_ts_q[rptr_q];
   assign issue       = (cnt_q != '0) && !hold && (age >= ELIG_AGE);

   always_comb begin
      cnt_d = cnt_q;
      case ({accept, issue})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         now_q      <= '0;
         resp_val_q <= 1'b0;
         resp_tid_q <= '0;
         resp_err_q <= 1'b0;
         rd_q       <= '0;
      end else begin
         now_q      <= now_q + 8'd1;
         cnt_q      <= cnt_d;
         resp_val_q <= issue;
         if (accept) wptr_q <= wptr_q + PTR_W'(1);
         if (issue) begin
            rptr_q     <= rptr_q + PTR_W'(1);
            resp_tid_q <= ent_tid_q[rptr_q];
            resp_err_q <= ent_err_q[rptr_q];
            rd_q       <= line_mem[ent_idx_q[rptr_q]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         ent_tid_q[wptr_q] <= mem_req_transid;
         ent_idx_q[wptr_q] <= req_idx;
         ent_err_q[wptr_q] <= req_err;
         ent_ts_q[wptr_q]  <= now_q;
      end
   end

   // Store is never reset; a same-cycle read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (wr_en) line_mem[wr_idx] <= wr_data;
   end

   assign mem_resp_val     = resp_val_q;
   assign mem_resp_transid = resp_tid_q;
   assign mem_resp_err     = resp_err_q;
   assign mem_resp_data    = resp_err_q ? '0 : rd_q;
   assign q_count          = cnt_q;

endmodule

// File: tb/tb_dcp_mem_responder.sv
// Directed bench for dcp_mem_responder: latency, streaming, full/hold, range errors,
// write collision and mid-flight reset.
module tb_dcp_mem_responder;

   localparam logic [39:0] BASE = 40'h00_0010_0000;

   logic         clk, rst_n, mem_req_val, hold, wr_en;
   logic         mem_req_rdy, mem_resp_val, mem_resp_err;
   logic [5:0]   mem_req_transid, mem_resp_transid;
   logic [39:0]  mem_req_addr;
   logic [7:0]   wr_idx;
   logic [511:0] wr_data, mem_resp_data;
   logic [3:0]   q_count;

   int n_cmp = 0;
   int n_bad = 0;

   dcp_mem_responder #(.LINE_W(512), .NUM_LINES(256), .BASE_ADDR(BASE), .DEPTH(8), .LAT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
      .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
      .hold(hold), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
      .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
      .q_count(q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word i of line ln carries {salt, ln, i} so every word of every line is distinct.
   function automatic logic [511:0] mk_line(input int ln, input int salt);
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'((salt << 24) | (ln << 8) | i);
      return v;
   endfunction

   function automatic logic [39:0] addr_of(input int ln, input int off);
      return BASE + (40'(ln) << 6) + 40'(off);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_line(input int idx, input logic [511:0] d);
      wr_en = 1'b1; wr_idx = 8'(idx); wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      n_cmp++; if (mem_req_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", mem_req_rdy); end
      n_cmp++; if (q_count !== 4'd0) begin n_bad++; $display("FAIL reset_qcount got %0d want 0", q_count); end
      n_cmp++; if (mem_resp_val !== 1'b0) begin n_bad++; $display("FAIL reset_val got %b want 0", mem_resp_val); end
      n_cmp++; if (mem_resp_transid !== 6'd0 || mem_resp_err !== 1'b0 || mem_resp_data !== 512'd0) begin
         n_bad++; $display("FAIL reset_resp got tid=%h err=%b data=%h want all zero", mem_resp_transid, mem_resp_err, mem_resp_data);
      end
   endtask

   task automatic test_single();
      mem_req_val = 1'b1; mem_req_transid = 6'h0; mem_req_addr = BASE + 40'h140 + 40'h24;
      n_cmp++; if (mem_req_rdy !== 1'b1) begin n_bad++; $display("FAIL single_rdy got %b want 1", mem_req_rdy); end
      tick();
      mem_req_val = 1'b0;
      for (int k = 1; k < 4; k++) begin
         n_cmp++; if (mem_resp_val !== 1'b0) begin n_bad++; $display("FAIL single_early cycle %0d got val %b want 0", k, mem_resp_val); end
         tick();
      end
      n_cmp++; if (mem_resp_val !== 1'b1) begin n_bad++; $display("FAIL single_lat got val %b want 1", mem_resp_val); end
      n_cmp++; if (mem_resp_transid !== 6'h0 || mem_resp_err !== 1'b0) begin
         n_bad++; $display("FAIL single_tag got tid=%h err=%b want tid=00 err=0", mem_resp_transid, mem_resp_err);
      end
      n_cmp++; if (mem_resp_data !== mk_line(5, 1)) begin n_bad++; $display("FAIL single_data got %h want %h", mem_resp_data, mk_line(5, 1)); end
      tick();
      n_cmp++; if (mem_resp_val !== 1'b0) begin n_bad++; $display("FAIL single_pulse got val %b want 0", mem_resp_val); end
   endtask

   task automatic test_stream();
      for (int c = 0; c < 21; c++) begin
         mem_req_val = (c < 16);
         mem_req_transid = 6'(c);
         mem_req_addr = addr_of(c, 8);
         if (c < 16) begin
            n_cmp++; if (mem_req_rdy !== 1'b1) begin n_bad++; $display("FAIL stream_rdy c=%0d got %b want 1", c, mem_req_rdy); end
         end
         tick();
         if (c >= 3 && c < 19) begin
            n_cmp++;
            if (mem_resp_val !== 1'b1 || mem_resp_transid !== 6'(c - 3) || mem_resp_err !== 1'b0 || mem_resp_data !== mk_line(c - 3, 1)) begin
               n_bad++; $display("FAIL stream_resp c=%0d got val=%b tid=%h err=%b want val=1 tid=%h err=0", c, mem_resp_val, mem_resp_transid, mem_resp_err, 6'(c - 3));
            end
         end else begin
            n_cmp++; if (mem_resp_val !== 1'b0) begin n_bad++; $display("FAIL stream_idle c=%0d got val %b want 0", c, mem_resp_val); end
         end
      end
      mem_req_val = 1'b0;
   endtask

   task automatic test_full_hold();
      int acc = 0;
      bit take;
      for (int c = 0; c < 20; c++) begin
         hold = 1'b1; mem_req_val = 1'b1;
         mem_req_transid = 6'(32 + acc);
         mem_req_addr = addr_of(8 + acc, 0);
         take = mem_req_rdy;
         tick();
         if (take) acc++;
         n_cmp++; if (mem_resp_val !== 1'b0) begin n_bad++; $display("FAIL hold_quiet c=%0d got val %b want 0", c, mem_resp_val); end
      end
      n_cmp++; if (acc !== 8) begin n_bad++; $display("FAIL full_accepts got %0d want 8", acc); end
      n_cmp++; if (mem_req_rdy !== 1'b0) begin n_bad++; $display("FAIL full_rdy got %b want 0", mem_req_rdy); end
      n_cmp++; if (q_count !== 4'd8) begin n_bad++; $display("FAIL full_qcount got %0d want 8", q_count); end
      mem_req_val = 1'b0; hold = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 0) begin
            n_cmp++; if (mem_req_rdy !== 1'b1) begin n_bad++; $display("FAIL drain_rdy got %b want 1", mem_req_rdy); end
         end
         n_cmp++;
         if (mem_resp_val !== 1'b1 || mem_resp_transid !== 6'(32 + k) || mem_resp_data !== mk_line(8 + k, 1)) begin
            n_bad++; $display("FAIL drain_resp k=%0d got val=%b tid=%h want val=1 tid=%h", k, mem_resp_val, mem_resp_transid, 6'(32 + k));
         end
      end
      tick();
      n_cmp++; if (mem_resp_val !== 1'b0 || q_count !== 4'd0) begin
         n_bad++; $display("FAIL drain_end got val=%b q=%0d want val=0 q=0", mem_resp_val, q_count);
      end
   endtask

   task automatic test_range();
      logic [39:0] a [4];
      bit          e [4];
      int          ln [4];
      a  = '{BASE + 40'(256 * 64), addr_of(7, 5), BASE - 40'd64, addr_of(255, 63)};
      e  = '{1'b1, 1'b0, 1'b1, 1'b0};
      ln = '{0, 7, 0, 255};
      for (int c = 0; c < 8; c++) begin
         mem_req_val = (c < 4);
         mem_req_transid = 6'(48 + c);
         mem_req_addr = a[c % 4];
         tick();
         if (c >= 3 && c < 7) begin
            n_cmp++;
            if (mem_resp_val !== 1'b1 || mem_resp_transid !== 6'(45 + c) || mem_resp_err !== e[c - 3] ||
                mem_resp_data !== (e[c - 3] ? 512'd0 : mk_line(ln[c - 3], 1))) begin
               n_bad++; $display("FAIL range_resp r=%0d got val=%b tid=%h err=%b data=%h want err=%b", c - 3, mem_resp_val, mem_resp_transid, mem_resp_err, mem_resp_data, e[c - 3]);
            end
         end
      end
      mem_req_val = 1'b0;
   endtask

   task automatic test_collision();
      mem_req_val = 1'b1; mem_req_transid = 6'h3A; mem_req_addr = addr_of(3, 0);
      tick();
      mem_req_val = 1'b0;
      tick(); tick();
      wr_en = 1'b1; wr_idx = 8'd3; wr_data = mk_line(3, 2);
      tick();
      wr_en = 1'b0;
      n_cmp++; if (mem_resp_val !== 1'b1 || mem_resp_data !== mk_line(3, 1)) begin
         n_bad++; $display("FAIL collide_old got val=%b data=%h want old %h", mem_resp_val, mem_resp_data, mk_line(3, 1));
      end
      mem_req_val = 1'b1; mem_req_transid = 6'h3B;
      tick();
      mem_req_val = 1'b0;
      tick(); tick(); tick();
      n_cmp++; if (mem_resp_val !== 1'b1 || mem_resp_transid !== 6'h3B || mem_resp_data !== mk_line(3, 2)) begin
         n_bad++; $display("FAIL collide_new got val=%b tid=%h data=%h want %h", mem_resp_val, mem_resp_transid, mem_resp_data, mk_line(3, 2));
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      for (int c = 0; c < 3; c++) begin
         mem_req_val = 1'b1; mem_req_transid = 6'(16 + c); mem_req_addr = addr_of(c, 0);
         tick();
      end
      mem_req_val = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++; if (q_count !== 4'd0 || mem_req_rdy !== 1'b1) begin
         n_bad++; $display("FAIL midrst_q got q=%0d rdy=%b want q=0 rdy=1", q_count, mem_req_rdy);
      end
      n_cmp++; if (mem_resp_val !== 1'b0 || mem_resp_transid !== 6'd0 || mem_resp_data !== 512'd0 || mem_resp_err !== 1'b0) begin
         n_bad++; $display("FAIL midrst_resp got val=%b tid=%h err=%b want all zero", mem_resp_val, mem_resp_transid, mem_resp_err);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         n_cmp++; if (mem_resp_val !== 1'b0) begin n_bad++; $display("FAIL midrst_ghost k=%0d got val %b want 0", k, mem_resp_val); end
      end
      mem_req_val = 1'b1; mem_req_transid = 6'h11; mem_req_addr = addr_of(1, 0);
      tick();
      mem_req_val = 1'b0;
      tick(); tick(); tick();
      n_cmp++; if (mem_resp_val !== 1'b1 || mem_resp_transid !== 6'h11 || mem_resp_data !== mk_line(1, 1)) begin
         n_bad++; $display("FAIL midrst_store got val=%b tid=%h data=%h want %h", mem_resp_val, mem_resp_transid, mem_resp_data, mk_line(1, 1));
      end
   endtask

   initial begin
      rst_n = 1'b0; mem_req_val = 1'b0; hold = 1'b0; wr_en = 1'b0;
      mem_req_transid = '0; mem_req_addr = '0; wr_idx = '0; wr_data = '0;
      test_reset();
      for (int i = 0; i < 16; i++) wr_line(i, mk_line(i, 1));
      wr_line(255, mk_line(255, 1));
      test_single();
      test_stream();
      test_full_hold();
      test_range();
      test_collision();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
